// File: rtl/odometer_seq_ctrl.sv
// Sequencer for the stacked ring-oscillator odometer: config, reload, stress, measure, capture.
// Optional baseline-relative RES_DELTA output is built when ODO_DELTA_EN is defined.
module odometer_seq_ctrl #(
    parameter int unsigned STRESS_W      = 16,
    parameter int unsigned MEAS_W        = 16,
    parameter int unsigned ITER_W        = 8,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                AC_STRESS_CLK,
    input  logic                RESETB,
    input  logic                GO,
    input  logic                ABORT,
    input  logic                CFG_AC_DC,
    input  logic [2:0]          CFG_SEL_INV,
    input  logic [STRESS_W-1:0] CFG_STRESS_CYC,
    input  logic [MEAS_W-1:0]   CFG_MEAS_CYC,
    input  logic [ITER_W-1:0]   CFG_ITER,
    input  logic [11:0]         BF_COUNT,
    output logic                START,
    output logic                AC_DC,
    output logic                SEL_INV99,
    output logic                SEL_INV97,
    output logic                SEL_INV101,
    output logic                LOAD,
    output logic                MEAS_TRIG,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR,
    output logic                RES_VALID,
    output logic [11:0]         RES_COUNT,
    output logic [ITER_W-1:0]   RES_INDEX,
    output logic [12:0]         RES_DELTA
);
    localparam int unsigned CNT_W = (STRESS_W > MEAS_W) ? STRESS_W : MEAS_W;
    localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [STRESS_W-1:0] S_ONE    = {{(STRESS_W-1){1'b0}}, 1'b1};
    localparam logic [MEAS_W-1:0]   M_ONE    = {{(MEAS_W-1){1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0]   ITER_ONE = {{(ITER_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {StIdle, StConfig, StReload, StStress, StMeas, StCapture} state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [ITER_W-1:0]   idx_q;
    logic [ITER_W-1:0]   iter_q;
    logic [STRESS_W-1:0] stress_q;
    logic [MEAS_W-1:0]   meas_q;
    logic                ac_dc_q;
    logic [2:0]          sel_q;
    logic                fin_q;
    logic                last_q;

    logic [CNT_W-1:0] settle_ld, stress_ld, meas_ld;
    logic             active;

    assign settle_ld = CNT_W'(SETTLE_CYCLES - 1);
    assign stress_ld = (stress_q == '0) ? '0 : CNT_W'(stress_q - S_ONE);
    assign meas_ld   = CNT_W'(meas_q - M_ONE);
    assign active    = (state_q != StIdle);

    // Control outputs are a registered decode of the current state, so they trail it by one edge.
    always_ff @(posedge AC_STRESS_CLK or negedge RESETB) begin
        if (!RESETB) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            idx_q      <= '0;
            iter_q     <= '0;
            stress_q   <= '0;
            meas_q     <= '0;
            ac_dc_q    <= 1'b0;
            sel_q      <= '0;
            fin_q      <= 1'b0;
            last_q     <= 1'b0;
            START      <= 1'b0;
            AC_DC      <= 1'b0;
            SEL_INV99  <= 1'b0;
            SEL_INV97  <= 1'b0;
            SEL_INV101 <= 1'b0;
            LOAD       <= 1'b0;
            MEAS_TRIG  <= 1'b0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
            RES_VALID  <= 1'b0;
            RES_COUNT  <= '0;
            RES_INDEX  <= '0;
        end else begin
            START      <= active;
            BUSY       <= active;
            AC_DC      <= active & ac_dc_q;
            SEL_INV99  <= active & sel_q[0];
            SEL_INV97  <= active & sel_q[1];
            SEL_INV101 <= active & sel_q[2];
            LOAD       <= (state_q == StStress) || (state_q == StMeas) || (state_q == StCapture);
            MEAS_TRIG  <= (state_q == StMeas);
            ERR        <= 1'b0;
            RES_VALID  <= fin_q;
            DONE       <= fin_q & last_q;
            fin_q      <= 1'b0;
            last_q     <= 1'b0;
            if (ABORT && active) begin
                state_q    <= StIdle;
                START      <= 1'b0;
                BUSY       <= 1'b0;
                AC_DC      <= 1'b0;
                SEL_INV99  <= 1'b0;
                SEL_INV97  <= 1'b0;
                SEL_INV101 <= 1'b0;
                LOAD       <= 1'b0;
                MEAS_TRIG  <= 1'b0;
                RES_VALID  <= 1'b0;
                DONE       <= 1'b0;
                ERR        <= 1'b1;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (GO) begin
                            if (CFG_ITER != '0 && CFG_MEAS_CYC != '0) begin
                                ac_dc_q  <= CFG_AC_DC;
                                sel_q    <= CFG_SEL_INV;
                                stress_q <= CFG_STRESS_CYC;
                                meas_q   <= CFG_MEAS_CYC;
                                iter_q   <= CFG_ITER;
                                idx_q    <= '0;
                                cnt_q    <= settle_ld;
                                state_q  <= StConfig;
                            end else begin
                                ERR <= 1'b1;
                            end
                        end
                    end
                    StConfig: begin
                        if (cnt_q == '0) state_q <= StReload;
                        else             cnt_q   <= cnt_q - CNT_ONE;
                    end
                    StReload: begin
                        cnt_q   <= stress_ld;
                        state_q <= StStress;
                    end
                    StStress: begin
                        if (cnt_q == '0) begin
                            cnt_q   <= meas_ld;
                            state_q <= StMeas;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    StMeas: begin
                        if (cnt_q == '0) begin
                            cnt_q   <= settle_ld;
                            state_q <= StCapture;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    StCapture: begin
                        if (cnt_q == '0) begin
                            RES_COUNT <= BF_COUNT;
                            RES_INDEX <= idx_q;
                            idx_q     <= idx_q + ITER_ONE;
                            fin_q     <= 1'b1;
                            if (idx_q == iter_q - ITER_ONE) begin
                                last_q  <= 1'b1;
                                state_q <= StIdle;
                            end else begin
                                state_q <= StReload;
                            end
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef ODO_DELTA_EN
    logic        cap_fire;
    logic [11:0] base_q;

    assign cap_fire = (state_q == StCapture) && (cnt_q == '0) && !ABORT;

    always_ff @(posedge AC_STRESS_CLK or negedge RESETB) begin
        if (!RESETB) begin
            base_q    <= '0;
            RES_DELTA <= '0;
        end else if (cap_fire) begin
            if (idx_q == '0) begin
                base_q    <= BF_COUNT;
                RES_DELTA <= '0;
            end else begin
                RES_DELTA <= {1'b0, BF_COUNT} - {1'b0, base_q};
            end
        end
    end
`else
    assign RES_DELTA = '0;
`endif

endmodule

// File: tb/tb_odometer_seq_ctrl.sv
// Directed, table-driven bench for odometer_seq_ctrl: normal run timeline plus corner sequences.
module tb_odometer_seq_ctrl;
    logic        clk;
    logic        rst_n;
    logic        GO, ABORT, CFG_AC_DC;
    logic [2:0]  CFG_SEL_INV;
    logic [15:0] CFG_STRESS_CYC, CFG_MEAS_CYC;
    logic [7:0]  CFG_ITER;
    logic [11:0] BF_COUNT;
    logic        START, AC_DC, SEL_INV99, SEL_INV97, SEL_INV101, LOAD, MEAS_TRIG;
    logic        BUSY, DONE, ERR, RES_VALID;
    logic [11:0] RES_COUNT;
    logic [7:0]  RES_INDEX;
    logic [12:0] RES_DELTA;

    int n_chk = 0;
    int n_fail = 0;

    odometer_seq_ctrl dut (
        .AC_STRESS_CLK (clk),
        .RESETB        (rst_n),
        .GO            (GO),
        .ABORT         (ABORT),
        .CFG_AC_DC     (CFG_AC_DC),
        .CFG_SEL_INV   (CFG_SEL_INV),
        .CFG_STRESS_CYC(CFG_STRESS_CYC),
        .CFG_MEAS_CYC  (CFG_MEAS_CYC),
        .CFG_ITER      (CFG_ITER),
        .BF_COUNT      (BF_COUNT),
        .START         (START),
        .AC_DC         (AC_DC),
        .SEL_INV99     (SEL_INV99),
        .SEL_INV97     (SEL_INV97),
        .SEL_INV101    (SEL_INV101),
        .LOAD          (LOAD),
        .MEAS_TRIG     (MEAS_TRIG),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .ERR           (ERR),
        .RES_VALID     (RES_VALID),
        .RES_COUNT     (RES_COUNT),
        .RES_INDEX     (RES_INDEX),
        .RES_DELTA     (RES_DELTA)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int e;
        int start, load, meas, busy, rv, done, err, sel, acdc;
        int res_chk, cnt, idx;
    } vec_t;

    vec_t vec [18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Sets config and raises GO for one edge (E0); returns 1 time unit after E0.
    task automatic start_run(input logic [15:0] s, input logic [15:0] m, input logic [7:0] it);
        CFG_STRESS_CYC = s;
        CFG_MEAS_CYC   = m;
        CFG_ITER       = it;
        GO = 1'b1;
        tick();
        GO = 1'b0;
    endtask

    task automatic wait_rv(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (RES_VALID === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        check("res_valid_wait", 32'(ok), 32'd1);
    endtask

    initial begin
        int k;
        bit  seen;
        logic [31:0] exp_delta [3];

        //        e   st ld mt by rv dn er sel ac  rc  cnt     idx
        vec[0]  = '{0,  0, 0, 0, 0, 0, 0, 0, 0,  0,  1, 'h000, 0};
        vec[1]  = '{1,  1, 0, 0, 1, 0, 0, 0, 5,  1,  1, 'h000, 0};
        vec[2]  = '{4,  1, 0, 0, 1, 0, 0, 0, 5,  1,  1, 'h000, 0};
        vec[3]  = '{5,  1, 0, 0, 1, 0, 0, 0, 5,  1,  1, 'h000, 0};
        vec[4]  = '{6,  1, 1, 0, 1, 0, 0, 0, 5,  1,  1, 'h000, 0};
        vec[5]  = '{15, 1, 1, 0, 1, 0, 0, 0, 5,  1,  1, 'h000, 0};
        vec[6]  = '{16, 1, 1, 1, 1, 0, 0, 0, 5,  1,  1, 'h000, 0};
        vec[7]  = '{35, 1, 1, 1, 1, 0, 0, 0, 5,  1,  1, 'h000, 0};
        vec[8]  = '{36, 1, 1, 0, 1, 0, 0, 0, 5,  1,  1, 'h000, 0};
        vec[9]  = '{40, 1, 0, 0, 1, 1, 0, 0, 5,  1,  1, 'h123, 0};
        vec[10] = '{41, 1, 1, 0, 1, 0, 0, 0, 5,  1,  1, 'h123, 0};
        vec[11] = '{50, 1, 1, 0, 1, 0, 0, 0, 5,  1,  1, 'h123, 0};
        vec[12] = '{51, 1, 1, 1, 1, 0, 0, 0, 5,  1,  1, 'h123, 0};
        vec[13] = '{70, 1, 1, 1, 1, 0, 0, 0, 5,  1,  1, 'h123, 0};
        vec[14] = '{71, 1, 1, 0, 1, 0, 0, 0, 5,  1,  1, 'h123, 0};
        vec[15] = '{74, 1, 1, 0, 1, 0, 0, 0, 5,  1,  0, 'h000, 0};
        vec[16] = '{75, 0, 0, 0, 0, 1, 1, 0, 0,  0,  1, 'h130, 1};
        vec[17] = '{76, 0, 0, 0, 0, 0, 0, 0, 0,  0,  1, 'h130, 1};

`ifdef ODO_DELTA_EN
        exp_delta[0] = 32'h0000;
        exp_delta[1] = 32'h1FF0;
        exp_delta[2] = 32'h0010;
`else
        exp_delta[0] = 32'h0;
        exp_delta[1] = 32'h0;
        exp_delta[2] = 32'h0;
`endif

        rst_n = 1'b0;
        GO = 1'b0;
        ABORT = 1'b0;
        CFG_AC_DC = 1'b1;
        CFG_SEL_INV = 3'b101;
        CFG_STRESS_CYC = 16'd10;
        CFG_MEAS_CYC = 16'd20;
        CFG_ITER = 8'd2;
        BF_COUNT = 12'h123;
        tick();
        tick();
        check("reset_start", 32'(START), 32'd0);
        check("reset_busy", 32'(BUSY), 32'd0);
        check("reset_res_count", 32'(RES_COUNT), 32'd0);
        rst_n = 1'b1;
        tick();

        // Normal run: timeline checked against the vector table.
        start_run(16'd10, 16'd20, 8'd2);
        CFG_SEL_INV = 3'b010;
        CFG_AC_DC = 1'b0;
        CFG_ITER = 8'd5;
        k = 0;
        for (int n = 0; n <= 76; n++) begin
            if (n > 0) tick();
            if (k < 18 && vec[k].e == n) begin
                check($sformatf("start@E%0d", n), 32'(START), vec[k].start);
                check($sformatf("load@E%0d", n), 32'(LOAD), vec[k].load);
                check($sformatf("meas_trig@E%0d", n), 32'(MEAS_TRIG), vec[k].meas);
                check($sformatf("busy@E%0d", n), 32'(BUSY), vec[k].busy);
                check($sformatf("res_valid@E%0d", n), 32'(RES_VALID), vec[k].rv);
                check($sformatf("done@E%0d", n), 32'(DONE), vec[k].done);
                check($sformatf("err@E%0d", n), 32'(ERR), vec[k].err);
                check($sformatf("sel@E%0d", n), 32'({SEL_INV101, SEL_INV97, SEL_INV99}),
                      vec[k].sel);
                check($sformatf("ac_dc@E%0d", n), 32'(AC_DC), vec[k].acdc);
                if (vec[k].res_chk != 0) begin
                    check($sformatf("res_count@E%0d", n), 32'(RES_COUNT), vec[k].cnt);
                    check($sformatf("res_index@E%0d", n), 32'(RES_INDEX), vec[k].idx);
                end
                k++;
            end
            if (n == 40) BF_COUNT = 12'h130;
        end
        CFG_SEL_INV = 3'b101;
        CFG_AC_DC = 1'b1;

        // Rejected starts.
        start_run(16'd10, 16'd20, 8'd0);
        check("rej_iter_err", 32'(ERR), 32'd1);
        check("rej_iter_busy", 32'(BUSY), 32'd0);
        tick();
        check("rej_iter_err_clear", 32'(ERR), 32'd0);
        start_run(16'd10, 16'd0, 8'd2);
        check("rej_meas_err", 32'(ERR), 32'd1);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (BUSY !== 1'b0 || LOAD !== 1'b0 || START !== 1'b0) seen = 1'b1;
        end
        check("rej_stays_idle", 32'(seen), 32'd0);

        // Zero stress cycles: STRESS lasts one cycle.
        start_run(16'd0, 16'd5, 8'd1);
        for (int n = 1; n <= 16; n++) begin
            tick();
            if (n == 5) check("zs_load_low", 32'(LOAD), 32'd0);
            if (n == 6) check("zs_stress_meas", 32'(MEAS_TRIG), 32'd0);
            if (n == 7) check("zs_meas_rise", 32'(MEAS_TRIG), 32'd1);
            if (n == 11) check("zs_meas_last", 32'(MEAS_TRIG), 32'd1);
            if (n == 12) check("zs_meas_fall", 32'(MEAS_TRIG), 32'd0);
            if (n == 16) check("zs_done", 32'(DONE), 32'd1);
        end

        // Abort during MEAS of iteration 1.
        BF_COUNT = 12'h0AA;
        start_run(16'd3, 16'd10, 8'd3);
        wait_rv(100);
        BF_COUNT = 12'h555;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            tick();
            if (MEAS_TRIG === 1'b1) seen = 1'b1;
        end
        check("abort_reach_meas", 32'(seen), 32'd1);
        tick();
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("abort_err", 32'(ERR), 32'd1);
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_load", 32'(LOAD), 32'd0);
        check("abort_meas", 32'(MEAS_TRIG), 32'd0);
        check("abort_start", 32'(START), 32'd0);
        check("abort_index", 32'(RES_INDEX), 32'd0);
        check("abort_count", 32'(RES_COUNT), 32'h0AA);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (RES_VALID !== 1'b0 || DONE !== 1'b0 || ERR !== 1'b0 || BUSY !== 1'b0) seen = 1'b1;
        end
        check("abort_quiet", 32'(seen), 32'd0);
        ABORT = 1'b1;
        tick();
        ABORT = 1'b0;
        check("abort_idle_ignored", 32'(ERR), 32'd0);

        // Asynchronous reset in STRESS, then a clean restart.
        start_run(16'd10, 16'd5, 8'd1);
        repeat (7) tick();
        check("pre_reset_load", 32'(LOAD), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_load", 32'(LOAD), 32'd0);
        check("async_rst_start", 32'(START), 32'd0);
        check("async_rst_busy", 32'(BUSY), 32'd0);
        check("async_rst_count", 32'(RES_COUNT), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        BF_COUNT = 12'h077;
        start_run(16'd10, 16'd5, 8'd1);
        tick();
        check("restart_start", 32'(START), 32'd1);
        repeat (4) tick();
        check("restart_load_low", 32'(LOAD), 32'd0);
        wait_rv(100);
        check("restart_index", 32'(RES_INDEX), 32'd0);
        check("restart_count", 32'(RES_COUNT), 32'h077);
        check("restart_done", 32'(DONE), 32'd1);

        // Baseline delta over three iterations.
        tick();
        BF_COUNT = 12'h200;
        start_run(16'd2, 16'd3, 8'd3);
        wait_rv(100);
        check("delta0", 32'(RES_DELTA), exp_delta[0]);
        BF_COUNT = 12'h1F0;
        wait_rv(100);
        check("delta1", 32'(RES_DELTA), exp_delta[1]);
        check("delta1_index", 32'(RES_INDEX), 32'd1);
        BF_COUNT = 12'h210;
        wait_rv(100);
        check("delta2", 32'(RES_DELTA), exp_delta[2]);
        check("delta2_done", 32'(DONE), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/odometer_seq_ctrl.md
# odometer_seq_ctrl

Sequencer for the stacked ring-oscillator odometer. It configures the odometer's stress mode and inverter selection, then runs a programmable number of stress/measure iterations. Each iteration asserts the odometer's LOAD and MEAS_TRIG in order and captures BF_COUNT into a result register. It sits between the chip's config/scan registers and the odometer instance, and replaces hand-driven bench sequencing of those pins.

## Interface
Parameters:
- STRESS_W, 16, width of the stress-cycle count
- MEAS_W, 16, width of the measure-cycle count
- ITER_W, 8, width of the iteration count and index
- SETTLE_CYCLES, 4, cycles spent in CONFIG and in CAPTURE (must be ≥1)

Ports:
- AC_STRESS_CLK  in  1  block clock, rising edge
- RESETB  in  1  asynchronous, active-low reset
- GO  in  1  start request, sampled only in IDLE
- ABORT  in  1  terminate the sequence
- CFG_AC_DC  in  1  stress mode for the odometer
- CFG_SEL_INV  in  3  inverter select: bit0→SEL_INV99, bit1→SEL_INV97, bit2→SEL_INV101
- CFG_STRESS_CYC  in  STRESS_W  stress cycles per iteration
- CFG_MEAS_CYC  in  MEAS_W  MEAS_TRIG-high cycles per iteration
- CFG_ITER  in  ITER_W  number of iterations
- BF_COUNT  in  12  odometer beat-frequency count
- START, AC_DC, SEL_INV99, SEL_INV97, SEL_INV101  out  1 each  odometer configuration
- LOAD, MEAS_TRIG  out  1 each  odometer control
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse at normal completion
- ERR  out  1  one-cycle pulse on rejected GO or on ABORT
- RES_VALID  out  1  one-cycle pulse when new result data is valid
- RES_COUNT  out  12  captured BF_COUNT
- RES_INDEX  out  ITER_W  iteration number of RES_COUNT, 0-based
- RES_DELTA  out  13  signed delta; see Configuration

## Operation
- All outputs are registered.
- Reset value of every output is 0.
- States: IDLE → CONFIG → RELOAD → STRESS → MEAS → CAPTURE, then RELOAD (more iterations remain) or IDLE (last iteration).
- IDLE:
  - On GO=1 with CFG_ITER≠0 and CFG_MEAS_CYC≠0, latch all CFG_* inputs and go to CONFIG.
  - On GO=1 with either of those fields zero, pulse ERR and stay in IDLE.
  - Changes to CFG_* after the latch have no effect.
- CONFIG: START=1, and AC_DC/SEL_INV* take the latched values. Lasts SETTLE_CYCLES cycles. START and the selects hold until the sequence returns to IDLE.
- RELOAD: LOAD=0 for 1 cycle. This re-arms the odometer.
- STRESS: LOAD=1, MEAS_TRIG=0. Lasts max(CFG_STRESS_CYC,1) cycles.
- MEAS: LOAD=1, MEAS_TRIG=1. Lasts CFG_MEAS_CYC cycles.
- CAPTURE: MEAS_TRIG=0, LOAD=1. Lasts SETTLE_CYCLES cycles.
- On the final CAPTURE cycle:
  - BF_COUNT is sampled into RES_COUNT and the iteration index into RES_INDEX.
  - RES_VALID pulses on the next cycle.
  - The index increments; it does not wrap, because index < CFG_ITER always holds.
- Last iteration: the state goes to IDLE. DONE and RES_VALID pulse together, and BUSY, START, LOAD and the selects return to 0 in that same cycle.
- ABORT=1 in any non-IDLE state:
  - Next cycle: IDLE, control outputs return to their reset values, ERR pulses.
  - No RES_VALID or DONE is produced for the interrupted iteration.
  - RES_COUNT and RES_INDEX keep their last values.
- ABORT has priority over every other transition.
- ABORT in IDLE is ignored.
- GO while BUSY=1 is ignored.
- RESETB low at any time forces IDLE and all outputs to 0 asynchronously.
- Phase counters are MAX(STRESS_W,MEAS_W) bits wide. They load N-1 on phase entry and exit at 0, so an all-ones count is legal.

## Timing
- E0 is the edge on which GO is sampled high. "En" means the register state after the nth edge following E0.
- Per-iteration length: 1 + max(S,1) + M + SETTLE_CYCLES cycles, where S = CFG_STRESS_CYC and M = CFG_MEAS_CYC.
- The first iteration is preceded by SETTLE_CYCLES cycles of CONFIG.
- MEAS_TRIG rises exactly 1 + max(S,1) cycles after LOAD falls.
- BF_COUNT must be stable during CAPTURE. It is sampled at the last CAPTURE edge; there is no synchronizer.

## Configuration
- Macro: ODO_DELTA_EN.
- With the macro defined:
  - The iteration-0 capture is stored as the baseline.
  - RES_DELTA = RES_COUNT − baseline, 13-bit two's complement, valid with RES_VALID.
  - RES_DELTA is 0 for index 0.
- Without the macro: RES_DELTA is tied to 0, no baseline register is built, and the port list is unchanged.

## Test plan
- Normal run (SETTLE_CYCLES=4, S=10, M=20, CFG_ITER=2, BF_COUNT=0x123 then 0x130):
  - START=1 from E1; LOAD low at E5 and E40.
  - MEAS_TRIG high E16–E35 and E51–E70.
  - RES_VALID at E40 with count 0x123, index 0.
  - RES_VALID and DONE at E75 with count 0x130, index 1; BUSY=0 at E75.
- Rejected start: GO with CFG_ITER=0, then GO with CFG_MEAS_CYC=0 → ERR pulses each time, BUSY stays 0, no LOAD edge.
- Zero stress: S=0, M=5 → STRESS lasts 1 cycle; MEAS_TRIG rises 2 cycles after LOAD falls.
- ABORT during MEAS of iteration 1 → next cycle all control outputs 0, ERR=1, no RES_VALID/DONE, RES_INDEX stays 0.
- Reset mid-STRESS: RESETB low → all outputs 0 immediately. Then GO after release → full sequence restarts from CONFIG with index 0.
- ODO_DELTA_EN defined, CFG_ITER=3, counts 0x200, 0x1F0, 0x210 → RES_DELTA = 0, −16, +16.
